// File: rtl/matrix_seq_ctrl.sv
// matrix_seq_ctrl: serial-commanded switch-matrix driver with static patterns, walking-one scan and break-before-make dead time
module matrix_seq_ctrl #(
    parameter int          N_LINES     = 10,
    parameter int          DEAD_CYCLES = 4,
    parameter int          PRESC       = 100,
    parameter logic [11:0] DWELL_RST   = 12'd10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               RPI_IO1,
    input  logic               RPI_IO2,
    input  logic               RPI_IO3,
    output logic [N_LINES-1:0] matrix_out,
    output logic               scan_active,
    output logic               frame_err
);
    localparam int DW = $clog2(DEAD_CYCLES + 1);
    localparam int PW = $clog2(PRESC + 1);

    typedef enum logic [1:0] {IDLE, DEAD, SCAN_DWELL, SCAN_DEAD} state_t;

    logic [1:0]         io1_sync_q, io1_sync_d, io2_sync_q, io2_sync_d, io3_sync_q, io3_sync_d;
    logic               io1_prev_q, io1_prev_d, io3_prev_q, io3_prev_d;
    logic [4:0]         bits_q, bits_d;
    logic [15:0]        shift_q, shift_d;
    logic               commit_q, commit_d, err_q, err_d;
    logic               io1_rise, io3_rise, io3_fall, shift_en;
    state_t             state_q, state_d;
    logic [N_LINES-1:0] pat_q, pat_d, target_q, target_d, payload_pat;
    logic [11:0]        dwell_q, dwell_d, run_dwell_q, run_dwell_d, tick_q, tick_d;
    logic [DW-1:0]      dead_q, dead_d;
    logic [PW-1:0]      presc_q, presc_d;
    logic [3:0]         line_q, line_d;

    assign matrix_out  = pat_q;
    assign scan_active = (state_q == SCAN_DWELL) || (state_q == SCAN_DEAD);
    assign frame_err   = err_q;

    always_comb begin
        io1_sync_d = {io1_sync_q[0], RPI_IO1};
        io2_sync_d = {io2_sync_q[0], RPI_IO2};
        io3_sync_d = {io3_sync_q[0], RPI_IO3};
        io1_prev_d = io1_sync_q[1];
        io3_prev_d = io3_sync_q[1];
        io1_rise   = io1_sync_q[1] & ~io1_prev_q;
        io3_rise   = io3_sync_q[1] & ~io3_prev_q;
        io3_fall   = ~io3_sync_q[1] & io3_prev_q;
        shift_en   = io1_rise & ~io3_sync_q[1];
        shift_d    = shift_en ? {shift_q[14:0], io2_sync_q[1]} : shift_q;
        // saturating at 17 keeps over-long frames distinguishable from exact 16-bit ones
        bits_d     = io3_fall ? 5'd0 : !shift_en ? bits_q : (bits_q == 5'd17) ? bits_q : bits_q + 5'd1;
        commit_d   = io3_rise && (bits_q == 5'd16);
        err_d      = io3_rise && (bits_q != 5'd0) && (bits_q != 5'd16);
    end

    always_comb begin
        state_d     = state_q;
        pat_d       = pat_q;
        target_d    = target_q;
        dwell_d     = dwell_q;
        run_dwell_d = run_dwell_q;
        tick_d      = tick_q;
        dead_d      = dead_q;
        presc_d     = presc_q;
        line_d      = line_q;
        payload_pat = shift_q[N_LINES-1:0];
        case (state_q)
            DEAD: begin
                if (dead_q == DW'(DEAD_CYCLES - 1)) begin
                    state_d = IDLE;
                    pat_d   = target_q;
                end else begin
                    dead_d = dead_q + DW'(1);
                end
            end
            SCAN_DEAD: begin
                if (dead_q == DW'(DEAD_CYCLES - 1)) begin
                    state_d     = SCAN_DWELL;
                    pat_d       = N_LINES'(1) << line_q;
                    presc_d     = '0;
                    tick_d      = '0;
                    run_dwell_d = dwell_q;
                end else begin
                    dead_d = dead_q + DW'(1);
                end
            end
            SCAN_DWELL: begin
                if (presc_q != PW'(PRESC - 1)) begin
                    presc_d = presc_q + PW'(1);
                end else begin
                    presc_d = '0;
                    if (tick_q != run_dwell_q - 12'd1) begin
                        tick_d = tick_q + 12'd1;
                    end else begin
                        state_d = SCAN_DEAD;
                        pat_d   = '0;
                        dead_d  = '0;
                        line_d  = (line_q == 4'(N_LINES - 1)) ? 4'd0 : line_q + 4'd1;
                    end
                end
            end
            default: ;
        endcase
        // a committed command overrides the normal sequencing step
        if (commit_q) begin
            case (shift_q[15:12])
                4'h1: begin
                    if (state_q != IDLE || (payload_pat != pat_q && pat_q != '0)) begin
                        state_d  = DEAD;
                        pat_d    = '0;
                        dead_d   = '0;
                        target_d = payload_pat;
                    end else begin
                        pat_d = payload_pat;
                    end
                end
                4'h2: dwell_d = (shift_q[11:0] == 12'd0) ? 12'd1 : shift_q[11:0];
                4'h3: begin
                    state_d = SCAN_DEAD;
                    line_d  = '0;
                    dead_d  = '0;
                    pat_d   = '0;
                end
                4'h4: begin
                    state_d = IDLE;
                    pat_d   = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            io1_sync_q  <= 2'b00;
            io2_sync_q  <= 2'b00;
            io3_sync_q  <= 2'b11;
            io1_prev_q  <= 1'b0;
            io3_prev_q  <= 1'b1;
            bits_q      <= '0;
            shift_q     <= '0;
            commit_q    <= 1'b0;
            err_q       <= 1'b0;
            state_q     <= IDLE;
            pat_q       <= '0;
            target_q    <= '0;
            dwell_q     <= DWELL_RST;
            run_dwell_q <= DWELL_RST;
            tick_q      <= '0;
            dead_q      <= '0;
            presc_q     <= '0;
            line_q      <= '0;
        end else begin
            io1_sync_q  <= io1_sync_d;
            io2_sync_q  <= io2_sync_d;
            io3_sync_q  <= io3_sync_d;
            io1_prev_q  <= io1_prev_d;
            io3_prev_q  <= io3_prev_d;
            bits_q      <= bits_d;
            shift_q     <= shift_d;
            commit_q    <= commit_d;
            err_q       <= err_d;
            state_q     <= state_d;
            pat_q       <= pat_d;
            target_q    <= target_d;
            dwell_q     <= dwell_d;
            run_dwell_q <= run_dwell_d;
            tick_q      <= tick_d;
            dead_q      <= dead_d;
            presc_q     <= presc_d;
            line_q      <= line_d;
        end
    end
endmodule

// File: tb/tb_matrix_seq_ctrl.sv
// tb_matrix_seq_ctrl: scoreboard bench; a timeline model predicts every output change and frame error
module tb_matrix_seq_ctrl;
    localparam int N = 10;
    localparam int D = 4;
    localparam int P = 2;
    localparam int HOR = 2000;
    localparam logic [11:0] DRST = 12'd10;

    logic clk = 1'b0, rst = 1'b1, io1 = 1'b0, io2 = 1'b0, io3 = 1'b1;
    logic [N-1:0] matrix_out;
    logic scan_active, frame_err;

    matrix_seq_ctrl #(.N_LINES(N), .DEAD_CYCLES(D), .PRESC(P), .DWELL_RST(DRST)) dut (
        .clk(clk), .rst(rst), .RPI_IO1(io1), .RPI_IO2(io2), .RPI_IO3(io3),
        .matrix_out(matrix_out), .scan_active(scan_active), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint       t;
        logic [N:0]   v;
    } ev_t;

    ev_t     exp_q[$];
    longint  err_q[$];
    longint  cyc = 0;
    int      errors = 0, checks = 0;
    int      m_mode = 0;
    logic [N-1:0] m_pat = '0, m_tgt = '0;
    longint  m_s = 0;
    longint  dw_t[$];
    int      dw_v[$];
    logic [N:0] last_obs = '0, obs;
    ev_t     ev;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int dwell_at(input longint e);
        for (int i = dw_t.size() - 1; i >= 0; i--)
            if (dw_t[i] <= e) return dw_v[i];
        return int'(DRST);
    endfunction

    // expected {scan_active, matrix_out} at cycle t if no further command arrives
    function automatic logic [N:0] val_at(input longint t);
        longint pos, e;
        int n;
        if (m_mode == 0) return {1'b0, m_pat};
        if (m_mode == 1) return (t < m_s + D) ? '0 : {1'b0, m_tgt};
        pos = m_s;
        n = 0;
        while (1) begin
            if (t < pos + D) return {1'b1, N'(0)};
            e = pos + D;
            pos = e + longint'(dwell_at(e) * P);
            if (t < pos) return {1'b1, N'(1) << n};
            n = (n + 1) % N;
        end
        return '0;
    endfunction

    task automatic emit(input longint c, input longint t, input logic [N:0] v, inout logic [N:0] last);
        if (t > c && v != last) begin
            exp_q.push_back('{t: t, v: v});
            last = v;
        end
    endtask

    task automatic replan(input longint c, input logic [N:0] prev);
        logic [N:0] last;
        longint pos, e;
        int n;
        last = prev;
        while (exp_q.size() > 0 && exp_q[exp_q.size() - 1].t > c) void'(exp_q.pop_back());
        if (m_mode == 0) begin
            emit(c, c + 1, {1'b0, m_pat}, last);
        end else if (m_mode == 1) begin
            emit(c, m_s, '0, last);
            emit(c, m_s + D, {1'b0, m_tgt}, last);
        end else begin
            pos = m_s;
            n = 0;
            while (pos <= c + HOR) begin
                emit(c, pos, {1'b1, N'(0)}, last);
                e = pos + D;
                emit(c, e, {1'b1, N'(1) << n}, last);
                pos = e + longint'(dwell_at(e) * P);
                n = (n + 1) % N;
            end
        end
    endtask

    // apply a committed command at cycle c (its effect is visible from c+1)
    task automatic command(input longint c, input logic [15:0] w);
        logic [N:0] prev;
        logic [N-1:0] t;
        prev = val_at(c);
        if (m_mode == 1 && c >= m_s + D) begin
            m_mode = 0;
            m_pat = m_tgt;
        end
        t = w[N-1:0];
        case (w[15:12])
            4'h1: if (m_mode == 0 && (t == m_pat || m_pat == '0)) m_pat = t;
                  else begin m_mode = 1; m_s = c + 1; m_tgt = t; end
            4'h2: begin dw_t.push_back(c + 2); dw_v.push_back(w[11:0] == 12'd0 ? 1 : int'(w[11:0])); end
            4'h3: begin m_mode = 2; m_s = c + 1; end
            4'h4: begin m_mode = 0; m_pat = '0; end
            default: return;
        endcase
        replan(c, prev);
    endtask

    task automatic send(input logic [31:0] w, input int nb);
        int ph;
        longint c;
        ph = $urandom_range(3, 5);
        @(negedge clk) io3 = 1'b0;
        repeat (ph) @(negedge clk);
        for (int i = nb - 1; i >= 0; i--) begin
            io2 = w[i];
            repeat (ph) @(negedge clk);
            io1 = 1'b1;
            repeat (ph) @(negedge clk);
            io1 = 1'b0;
        end
        repeat (ph) @(negedge clk);
        io3 = 1'b1;
        c = cyc + 3;
        if (nb == 16) command(c, w[15:0]);
        else if (nb != 0) err_q.push_back(c);
        repeat (5) @(negedge clk);
    endtask

    task automatic do_reset();
        logic [N:0] prev;
        longint c;
        @(negedge clk);
        c = cyc;
        prev = val_at(c);
        rst = 1'b1;
        m_mode = 0;
        m_pat = '0;
        dw_t.delete();
        dw_v.delete();
        replan(c, prev);
        for (int i = 0; i < 3; i++) begin
            io1 = 1'($urandom_range(0, 1));
            io2 = 1'($urandom_range(0, 1));
            io3 = 1'($urandom_range(0, 1));
            @(negedge clk);
            checks++;
            if (matrix_out !== '0 || scan_active !== 1'b0 || frame_err !== 1'b0) begin
                errors++;
                $display("FAIL reset_outputs: got out=%h scan=%b err=%b, required 0 0 0", matrix_out, scan_active, frame_err);
            end
        end
        io1 = 1'b0;
        io3 = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        if (cyc > 0) begin
            obs = {scan_active, matrix_out};
            if (obs !== last_obs) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL out_change: unexpected change at cycle %0d to %h", cyc, obs);
                end else begin
                    ev = exp_q.pop_front();
                    if (ev.t != cyc || ev.v !== obs) begin
                        errors++;
                        $display("FAIL out_event: got cycle %0d value %h, required cycle %0d value %h", cyc, obs, ev.t, ev.v);
                    end
                end
                last_obs = obs;
            end
            if (frame_err === 1'b1) begin
                checks++;
                if (err_q.size() == 0 || err_q[0] != cyc) begin
                    errors++;
                    $display("FAIL frame_err: pulse at cycle %0d, required cycle %0d", cyc, err_q.size() ? err_q[0] : -1);
                end
                if (err_q.size() > 0) void'(err_q.pop_front());
            end
        end
    end

    initial begin
        int r, overdue;
        do_reset();
        send(32'h1155, 16);
        repeat (10) @(negedge clk);
        send(32'h12AA, 16);
        send(32'h12AA, 16);
        send(32'h2003, 16);
        send(32'h3000, 16);
        repeat (110) @(negedge clk);
        send(32'h2000, 16);
        repeat (60) @(negedge clk);
        send(32'h4000, 16);
        send(32'h1155, 16);
        send(32'h0000_1AAA, 15);
        send(32'h000F_1AAA, 20);
        send(32'h7123, 16);
        send(32'h3000, 16);
        repeat (37) @(negedge clk);
        do_reset();
        for (int k = 0; k < 30; k++) begin
            r = $urandom_range(0, 9);
            if (r <= 3) send({20'h0, 4'h1, 12'($urandom)}, 16);
            else if (r == 4) send({20'h0, 4'h2, 12'($urandom_range(0, 3))}, 16);
            else if (r == 5) send(32'h3000, 16);
            else if (r == 6) send(32'h4000, 16);
            else if (r == 7) send({20'h0, 4'($urandom_range(5, 15)), 12'($urandom)}, 16);
            else if (r == 8) send($urandom, $urandom_range(0, 1) ? $urandom_range(1, 15) : $urandom_range(17, 20));
            else do_reset();
            repeat ($urandom_range(0, 150)) @(negedge clk);
        end
        repeat (20) @(negedge clk);
        overdue = 0;
        foreach (exp_q[i]) if (exp_q[i].t <= cyc) overdue++;
        foreach (err_q[i]) if (err_q[i] <= cyc) overdue++;
        checks++;
        if (overdue != 0) begin
            errors++;
            $display("FAIL drain: %0d expected events never seen, required 0", overdue);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
